wdata_chan_mngr_p: RTL and testbench

- Parametrised AXI write-data (W) channel manager. Sits between the master-side write engine and the AXI W channel.
- Accepts whole-burst write payloads with ID, length and byte strobes into a small request queue. Serialises each burst into DW-bit beats with wvalid/wlast.
- Reports burst completion with the originating ID. Back-to-back bursts run with no idle cycle.

---
 rtl/wdata_chan_mngr_p.sv | 110 +++++++++++
 tb/tb_wdata_chan_mngr_p.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wdata_chan_mngr_p.sv
// AXI write-data channel manager: queues whole-burst write payloads and
// serialises each one into DW-bit W beats, reporting completion by ID.
module wdata_chan_mngr_p #(
    parameter  int DW       = 32,
    parameter  int MAXBEATS = 4,
    parameter  int IDW      = 4,
    parameter  int QDEPTH   = 2,
    localparam int LW       = $clog2(MAXBEATS),
    localparam int SW       = DW / 8,
    localparam int QCW      = $clog2(QDEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   wvalid,
    input  logic                   wready,
    output logic [DW-1:0]          wdata,
    output logic [SW-1:0]          wstrb,
    output logic                   wlast,
    input  logic                   rq_valid,
    output logic                   rq_ready,
    input  logic [IDW-1:0]         rq_id,
    input  logic [LW-1:0]          rq_len,
    input  logic [DW*MAXBEATS-1:0] rq_wdata,
    input  logic [SW*MAXBEATS-1:0] rq_wstrb,
    output logic                   finish_wd,
    output logic [IDW-1:0]         finish_id,
    output logic [QCW-1:0]         q_count
);

    localparam int PW = $clog2(QDEPTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [IDW-1:0]         mem_id   [QDEPTH];
    logic [LW-1:0]          mem_len  [QDEPTH];
    logic [DW*MAXBEATS-1:0] mem_data [QDEPTH];
    logic [SW*MAXBEATS-1:0] mem_strb [QDEPTH];

    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [QCW-1:0] count_next;
    logic [0:0]     state, state_next;
    logic [LW-1:0]  beat;
    logic           push, pop, q_empty;

    assign q_empty   = (q_count == '0);
    assign rq_ready  = (q_count != QCW'(QDEPTH));
    assign push      = rq_valid & rq_ready;
    assign wvalid    = (state == BURST);
    assign wlast     = wvalid & (beat == mem_len[rd_ptr]);
    assign finish_wd = wvalid & wready & wlast;
    assign pop       = finish_wd;

    // Head-entry views are forced to zero while the queue holds nothing valid.
    assign wdata     = q_empty ? '0 : mem_data[rd_ptr][beat*DW +: DW];
    assign wstrb     = q_empty ? '0 : mem_strb[rd_ptr][beat*SW +: SW];
    assign finish_id = q_empty ? '0 : mem_id[rd_ptr];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        count_next = q_count;
        case ({push, pop})
            2'b10:   count_next = q_count + QCW'(1);
            2'b01:   count_next = q_count - QCW'(1);
            default: count_next = q_count;
        endcase
    end

    // Entering BURST on the push edge itself gives one-cycle request-to-wvalid latency.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (push || !q_empty) state_next = BURST;
            BURST:   if (pop && count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: the payload storage carries no reset; only pointers and counts do,
    // since an entry is never read before it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]   <= rq_id;
            mem_len[wr_ptr]  <= rq_len;
            mem_data[wr_ptr] <= rq_wdata;
            mem_strb[wr_ptr] <= rq_wstrb;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            state   <= IDLE;
            beat    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            q_count <= count_next;
            state   <= state_next;
            if (state != BURST || pop)
                beat <= '0;
            else if (wready)
                beat <= beat + LW'(1);
        end
    end

endmodule

// File: tb/tb_wdata_chan_mngr_p.sv
// Self-checking bench for wdata_chan_mngr_p: directed scenarios plus random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_wdata_chan_mngr_p;

    localparam int QDEPTH = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wvalid, wready, wlast;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         rq_valid, rq_ready;
    logic [3:0]   rq_id;
    logic [1:0]   rq_len;
    logic [127:0] rq_wdata;
    logic [15:0]  rq_wstrb;
    logic         finish_wd;
    logic [3:0]   finish_id;
    logic [1:0]   q_count;

    wdata_chan_mngr_p dut (
        .clk(clk), .rst_n(rst_n),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .rq_valid(rq_valid), .rq_ready(rq_ready), .rq_id(rq_id), .rq_len(rq_len),
        .rq_wdata(rq_wdata), .rq_wstrb(rq_wstrb),
        .finish_wd(finish_wd), .finish_id(finish_id), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   id;
        logic [1:0]   len;
        logic [127:0] data;
        logic [15:0]  strb;
    } req_t;

    req_t q[$];
    int   beat;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_fin = 0;
    bit   last_push;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the current cycle.
    task automatic check_all();
        logic [127:0] d;
        logic [15:0]  s;
        bit           busy, last;
        busy = (q.size() != 0);
        last = busy && (beat == int'(q[0].len));
        d = busy ? (q[0].data >> (32 * beat)) : 128'd0;
        s = busy ? (q[0].strb >> (4 * beat)) : 16'd0;
        check("wvalid",    32'(wvalid),    32'(busy));
        check("wlast",     32'(wlast),     32'(last));
        check("wdata",     wdata,          d[31:0]);
        check("wstrb",     32'(wstrb),     32'(s[3:0]));
        check("finish_wd", 32'(finish_wd), 32'(last && wready));
        check("finish_id", 32'(finish_id), busy ? 32'(q[0].id) : 32'd0);
        check("rq_ready",  32'(rq_ready),  32'(q.size() != QDEPTH));
        check("q_count",   32'(q_count),   32'(q.size()));
    endtask

    task automatic cycle(input logic v, input logic [3:0] id, input logic [1:0] len,
                         input logic [127:0] d, input logic [15:0] s, input logic wr);
        bit   do_push;
        req_t r;
        rq_valid = v; rq_id = id; rq_len = len; rq_wdata = d; rq_wstrb = s; wready = wr;
        @(negedge clk);
        check_all();
        do_push = v && (q.size() != QDEPTH);
        if (q.size() != 0 && wr) begin
            if (beat == int'(q[0].len)) begin
                void'(q.pop_front());
                beat = 0;
                n_fin++;
            end else begin
                beat++;
            end
        end
        if (do_push) begin
            r.id = id; r.len = len; r.data = d; r.strb = s;
            q.push_back(r);
        end
        last_push = do_push;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic wr);
        cycle(1'b0, 4'd0, 2'd0, 128'd0, 16'd0, wr);
    endtask

    task automatic do_reset();
        rq_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_wvalid",    32'(wvalid),    32'd0);
        check("rst_wlast",     32'(wlast),     32'd0);
        check("rst_finish_wd", 32'(finish_wd), 32'd0);
        check("rst_q_count",   32'(q_count),   32'd0);
        check("rst_rq_ready",  32'(rq_ready),  32'd1);
        check("rst_wdata",     wdata,          32'd0);
        check("rst_finish_id", 32'(finish_id), 32'd0);
        q.delete();
        beat = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] WORDS = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    initial begin
        int fin0;
        bit got;
        beat = 0;
        rst_n = 1'b1; wready = 1'b1; rq_valid = 1'b0; rq_id = '0; rq_len = '0;
        rq_wdata = '0; rq_wstrb = '0;
        #2;
        do_reset();

        // Single 4-beat burst.
        fin0 = n_fin;
        cycle(1'b1, 4'd3, 2'd3, WORDS, 16'hFFFF, 1'b1);
        repeat (5) idle(1'b1);
        check("burst4_finishes", 32'(n_fin - fin0), 32'd1);

        // Single beat with partial strobes.
        cycle(1'b1, 4'd5, 2'd0, 128'hDEADBEEF, 16'h0003, 1'b1);
        repeat (2) idle(1'b1);

        // Two back-to-back bursts.
        cycle(1'b1, 4'd1, 2'd1, WORDS, 16'hA5A5, 1'b1);
        cycle(1'b1, 4'd2, 2'd3, ~WORDS, 16'h0F0F, 1'b1);
        repeat (7) idle(1'b1);

        // wready toggling 1,0,0,1 during a burst.
        fin0 = n_fin;
        cycle(1'b1, 4'd7, 2'd3, WORDS, 16'h1234, 1'b1);
        for (int i = 0; i < 16; i++) idle((i % 4) == 0 || (i % 4) == 3);
        check("toggle_finishes", 32'(n_fin - fin0), 32'd1);

        // Fill with wready low, third request held until a slot frees.
        cycle(1'b1, 4'd8, 2'd1, WORDS, 16'hFFFF, 1'b0);
        cycle(1'b1, 4'd9, 2'd0, WORDS, 16'hFFFF, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'hA, 2'd2, ~WORDS, 16'h00FF, 1'b0);
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1'b1, 4'hA, 2'd2, ~WORDS, 16'h00FF, 1'b1);
            got = last_push;
        end
        check("held_req_accepted", 32'(got), 32'd1);
        repeat (8) idle(1'b1);

        // Reset in the middle of a burst, then a fresh burst from beat 0.
        fin0 = n_fin;
        cycle(1'b1, 4'd4, 2'd3, WORDS, 16'hFFFF, 1'b1);
        idle(1'b1);
        idle(1'b1);
        do_reset();
        check("rst_no_finish", 32'(n_fin - fin0), 32'd0);
        cycle(1'b1, 4'd6, 2'd2, ~WORDS, 16'hC3C3, 1'b1);
        repeat (4) idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'(($urandom % 3) != 0), 4'($urandom), 2'($urandom),
                  {$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
                  1'(($urandom % 4) != 0));
        end
        repeat (12) idle(1'b1);
        check("drained", 32'(q_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
